fetch_unit: RTL and testbench

//  Instruction-fetch stage of the 5-stage pipeline. Owns the PC register and issues

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: a valid/ready request channel
// and a valid-only response channel.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding,
// presents the fetched word to IF/ID, and drops stale responses after redirects.
//
// state | meaning
// IDLE  | just out of reset, responses ignored
// FETCH | request for PC on the bus, waiting for ready
// WAIT  | request accepted, waiting for the response
// HAVE  | instruction held on F_instr until IF/ID takes it
// DRAIN | redirected while a request was in flight; discard its response
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master imem,
  output logic [31:0]  F_instr,
  output logic [31:0]  F_PC,
  output logic [31:0]  F_PC_P4,
  output logic         F_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HAVE,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr_q;
  logic        r_valid;

  state_t      w_nxt_state;
  logic [31:0] w_nxt_pc;
  logic [31:0] w_nxt_instr;
  logic        w_nxt_valid;
  logic        w_handshake;
  logic [31:0] w_pc_p4;
  logic [31:0] w_redirect_pc;

  assign w_pc_p4       = r_pc + 32'd4;
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_handshake   = (r_state == S_FETCH) && imem.imem_req_ready;

  assign imem.imem_req_valid = (r_state == S_FETCH);
  assign imem.imem_req_addr  = r_pc;

  assign F_valid = r_valid;
  assign F_instr = r_valid ? r_instr_q : NOP_INSTR;
  assign F_PC    = r_pc;
  assign F_PC_P4 = w_pc_p4;

  // Next-state logic; a redirect outside IDLE overrides every other event.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = r_pc;
    w_nxt_instr = r_instr_q;
    w_nxt_valid = r_valid;

    case (r_state)
      S_IDLE:  w_nxt_state = S_FETCH;
      S_FETCH: if (w_handshake) w_nxt_state = S_WAIT;
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          w_nxt_instr = imem.imem_rsp_data;
          w_nxt_valid = 1'b1;
          w_nxt_state = S_HAVE;
        end
      end
      S_HAVE: begin
        if (!stall) begin
          w_nxt_pc    = w_pc_p4;
          w_nxt_valid = 1'b0;
          w_nxt_state = S_FETCH;
        end
      end
      S_DRAIN: if (imem.imem_rsp_valid) w_nxt_state = S_FETCH;
      default: w_nxt_state = S_IDLE;
    endcase

    if (redirect && (r_state != S_IDLE)) begin
      w_nxt_pc    = w_redirect_pc;
      w_nxt_valid = 1'b0;
      w_nxt_instr = r_instr_q;
      case (r_state)
        S_FETCH: w_nxt_state = w_handshake ? S_DRAIN : S_FETCH;
        S_WAIT:  w_nxt_state = imem.imem_rsp_valid ? S_FETCH : S_DRAIN;
        S_DRAIN: w_nxt_state = imem.imem_rsp_valid ? S_FETCH : S_DRAIN;
        default: w_nxt_state = S_FETCH;
      endcase
    end
  end

  // State, PC and held-instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_instr_q <= NOP_INSTR;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_pc      <= w_nxt_pc;
      r_instr_q <= w_nxt_instr;
      r_valid   <= w_nxt_valid;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a small imem model answers requests, expected
// (PC, instruction) pairs are queued and checked as IF/ID consumes them.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0_n, rst1_n;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr0, pc0, pcp4_0, instr1, pc1, pcp4_1;
  logic        valid0, valid1;

  fetch_unit_if u_if0 ();
  fetch_unit_if u_if1 ();

  fetch_unit u_dut0 (
    .clk(clk), .rst_n(rst0_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(u_if0),
    .F_instr(instr0), .F_PC(pc0), .F_PC_P4(pcp4_0), .F_valid(valid0)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(u_if1),
    .F_instr(instr1), .F_PC(pc1), .F_PC_P4(pcp4_1), .F_valid(valid1)
  );

  always #5 clk = ~clk;

  // Selected DUT view (sel=0: default RESET_PC, sel=1: RESET_PC=FFFFFFFC)
  logic        sel;
  logic        m_rst_n, m_valid, m_req_valid;
  logic [31:0] m_instr, m_pc, m_p4, m_req_addr;
  assign m_rst_n     = sel ? rst1_n : rst0_n;
  assign m_valid     = sel ? valid1 : valid0;
  assign m_instr     = sel ? instr1 : instr0;
  assign m_pc        = sel ? pc1 : pc0;
  assign m_p4        = sel ? pcp4_1 : pcp4_0;
  assign m_req_valid = sel ? u_if1.imem_req_valid : u_if0.imem_req_valid;
  assign m_req_addr  = sel ? u_if1.imem_req_addr : u_if0.imem_req_addr;

  int   n_chk = 0;
  int   n_bad = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return addr ^ 32'h5A5A_A5A5;
  endfunction

  function automatic void push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_data(pc);
    sb.push_back(e);
  endfunction

  // imem model: accepts when ready, answers rsp_lat cycles later
  logic        ready_en;
  int          rsp_lat;
  int          n_acc = 0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;

  initial begin
    u_if0.imem_req_ready = 1'b0; u_if0.imem_rsp_valid = 1'b0; u_if0.imem_rsp_data = '0;
    u_if1.imem_req_ready = 1'b0; u_if1.imem_rsp_valid = 1'b0; u_if1.imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      u_if0.imem_rsp_valid = 1'b0;
      u_if1.imem_rsp_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          pend = 1'b0;
          if (sel) begin
            u_if1.imem_rsp_valid = 1'b1; u_if1.imem_rsp_data = mem_data(pend_addr);
          end else begin
            u_if0.imem_rsp_valid = 1'b1; u_if0.imem_rsp_data = mem_data(pend_addr);
          end
        end
      end
      u_if0.imem_req_ready = ready_en && !sel;
      u_if1.imem_req_ready = ready_en && sel;
      if (m_req_valid && ready_en) begin
        pend      = 1'b1;
        cnt       = rsp_lat;
        pend_addr = m_req_addr;
        n_acc++;
      end
    end
  end

  // Consumption monitor: an instruction leaves fetch when valid and not stalled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_rst_n) begin
        if (m_valid && !stall) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected", m_pc, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("out_pc", m_pc, e.pc);
            chk("out_pc_p4", m_p4, e.pc + 32'd4);
            chk("out_instr", m_instr, e.instr);
          end
        end else if (!m_valid) begin
          chk("nop_when_invalid", m_instr, NOP);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 60) begin
      step();
      n++;
    end
    if (!m_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic consume();
    stall = 1'b0;
    step();
    stall = 1'b1;
  endtask

  task automatic take(input string tag);
    wait_valid(tag);
    consume();
  endtask

  initial begin
    int acc0;
    sel = 1'b0; rst0_n = 1'b0; rst1_n = 1'b0;
    stall = 1'b1; redirect = 1'b0; redirect_pc = '0;
    ready_en = 1'b1; rsp_lat = 1;
    repeat (2) step();

    // reset values
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_instr", instr0, NOP);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_pc_p4", pcp4_0, 32'h4);
    chk("rst_req_valid", {31'd0, u_if0.imem_req_valid}, 32'd0);

    // 1: straight-line fetch
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    rst0_n = 1'b1;
    step();
    chk("t1_req_valid", {31'd0, m_req_valid}, 32'd1);
    chk("t1_req_addr", m_req_addr, 32'h0);
    step();
    chk("t1_not_yet_valid", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 4; i++) take("t1");

    // 2: stall in HAVE at 0x10
    wait_valid("t2");
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_valid", {31'd0, m_valid}, 32'd1);
      chk("t2_hold_pc", m_pc, 32'h10);
      chk("t2_hold_instr", m_instr, mem_data(32'h10));
      chk("t2_no_req", {31'd0, m_req_valid}, 32'd0);
      step();
    end
    push(32'h10); push(32'h14);
    take("t2a");
    take("t2b");

    // 3: redirect in WAIT, stale response arrives while draining
    rsp_lat = 3;
    step();
    chk("t3_in_wait", {31'd0, m_req_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    rsp_lat = 1;
    chk("t3_drain_valid", {31'd0, m_valid}, 32'd0);
    chk("t3_drain_noreq", {31'd0, m_req_valid}, 32'd0);
    chk("t3_drain_pc", m_pc, 32'h200);
    step();
    chk("t3_drain_noreq2", {31'd0, m_req_valid}, 32'd0);
    step();
    chk("t3_refetch_req", {31'd0, m_req_valid}, 32'd1);
    chk("t3_refetch_addr", m_req_addr, 32'h200);
    push(32'h200);
    take("t3");

    // 4: redirect to unaligned target in HAVE with stall held
    wait_valid("t4_have");
    chk("t4_have_pc", m_pc, 32'h204);
    redirect = 1'b1; redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    chk("t4_valid_drop", {31'd0, m_valid}, 32'd0);
    chk("t4_pc", m_pc, 32'h100);
    chk("t4_pc_p4", m_p4, 32'h104);
    chk("t4_req_valid", {31'd0, m_req_valid}, 32'd1);
    chk("t4_req_addr", m_req_addr, 32'h100);
    push(32'h100);
    wait_valid("t4");
    ready_en = 1'b0;
    consume();

    // 5: request refused, then redirected before acceptance
    acc0 = n_acc;
    chk("t5_req_valid", {31'd0, m_req_valid}, 32'd1);
    chk("t5_req_addr0", m_req_addr, 32'h104);
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("t5_req_addr1", m_req_addr, 32'h40);
    step();
    chk("t5_req_addr2", m_req_addr, 32'h40);
    chk("t5_no_accept_yet", n_acc - acc0, 32'd0);
    ready_en = 1'b1;
    push(32'h40);
    wait_valid("t5");
    chk("t5_one_accept", n_acc - acc0, 32'd1);
    chk("t5_pc", m_pc, 32'h40);
    ready_en = 1'b0;
    consume();

    // 6: RESET_PC at top of address space, reset during WAIT
    rst0_n = 1'b0;
    step(); step();
    sel = 1'b1;
    chk("t6_rst_pc", pc1, 32'hFFFF_FFFC);
    chk("t6_rst_pc_p4", pcp4_1, 32'h0);
    ready_en = 1'b1;
    push(32'hFFFF_FFFC); push(32'h0);
    rst1_n = 1'b1;
    take("t6a");
    take("t6b");
    rsp_lat = 3;
    step();
    chk("t6_in_wait_pc", m_pc, 32'h4);
    rst1_n = 1'b0;
    ready_en = 1'b0;
    #1;
    chk("t6_arst_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_arst_instr", m_instr, NOP);
    chk("t6_arst_pc", m_pc, 32'hFFFF_FFFC);
    chk("t6_arst_pc_p4", m_p4, 32'h0);
    chk("t6_arst_req", {31'd0, m_req_valid}, 32'd0);
    step(); step();
    rst1_n = 1'b1;
    step();
    chk("t6_late_rsp_ignored", {31'd0, m_valid}, 32'd0);
    chk("t6_refetch_req", {31'd0, m_req_valid}, 32'd1);
    chk("t6_refetch_addr", m_req_addr, 32'hFFFF_FFFC);
    step();
    chk("t6_still_invalid", {31'd0, m_valid}, 32'd0);
    rsp_lat = 1;
    ready_en = 1'b1;
    push(32'hFFFF_FFFC);
    take("t6c");
    step();
    chk("sb_left", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
